// File: rtl/pixel_clip_fifo.sv
// pixel_clip_fifo: clips signed pixel requests to the screen, buffers survivors, strobes them to vga_adapter.
// Ports: clock/resetn (async active-low); start begins a shape; hold stalls the output side;
// in_valid/in_ready/in_x/in_y/in_colour/in_last form the request handshake; vga_x/vga_y/vga_colour/vga_plot
// drive the adapter; done is set once the last pixel has drained; clipped_count counts discarded pixels
// (saturating); level is the FIFO occupancy.
module pixel_clip_fifo #(
    parameter int DEPTH   = 16,
    parameter int COORD_W = 9,
    parameter int X_MAX   = 159,
    parameter int Y_MAX   = 119
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       hold,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [COORD_W-1:0]  in_x,
    input  logic signed [COORD_W-1:0]  in_y,
    input  logic [2:0]                 in_colour,
    input  logic                       in_last,
    output logic [7:0]                 vga_x,
    output logic [6:0]                 vga_y,
    output logic [2:0]                 vga_colour,
    output logic                       vga_plot,
    output logic                       done,
    output logic [15:0]                clipped_count,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [COORD_W-1:0] XM = COORD_W'(X_MAX);
    localparam logic signed [COORD_W-1:0] YM = COORD_W'(Y_MAX);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [17:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic acc, on_screen, push, pop, restart;
    assign in_ready  = (state == RUN) && (level < (AW+1)'(DEPTH));
    assign acc       = in_valid && in_ready;
    // sign bit clear means >= 0; upper bound is a signed compare at full coordinate width
    assign on_screen = !in_x[COORD_W-1] && !in_y[COORD_W-1] && (in_x <= XM) && (in_y <= YM);
    assign push      = acc && on_screen;
    assign pop       = !hold && (level != '0);
    assign restart   = start && (state == IDLE || state == DONE);
    assign done      = (state == DONE);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = start ? RUN : IDLE;
            RUN:   state_nx = (acc && in_last) ? DRAIN : RUN;
            DRAIN: state_nx = (level == '0) ? DONE : DRAIN;
            DONE:  state_nx = start ? RUN : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {in_x[7:0], in_y[6:0], in_colour};
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            clipped_count <= '0;
            vga_x         <= '0;
            vga_y         <= '0;
            vga_colour    <= '0;
            vga_plot      <= 1'b0;
        end else begin
            state    <= state_nx;
            vga_plot <= pop;
            level    <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                {vga_x, vga_y, vga_colour} <= mem[rd_ptr];
            end
            if (restart) clipped_count <= '0;
            else if (acc && !on_screen && clipped_count != 16'hFFFF) clipped_count <= clipped_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_pixel_clip_fifo.sv
// tb_pixel_clip_fifo: table vectors, directed corner sequences and randomized shapes against a queue model.
module tb_pixel_clip_fifo;
    logic clock = 0, resetn = 0, start = 0, hold = 0, in_valid = 0, in_last = 0;
    logic signed [8:0] in_x = 0, in_y = 0;
    logic [2:0] in_colour = 0;
    logic in_ready, vga_plot, done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic [15:0] clipped_count;
    logic [4:0] level;
    int n_chk = 0, n_fail = 0, cyc = 0, exp_clip = 0;
    bit rhold = 0;
    logic [17:0] plots[$], expq[$];
    int plot_cyc[$];
    typedef struct { int x; int y; int c; int on; } vec_t;
    vec_t tbl[12];

    pixel_clip_fifo dut (.clock(clock), .resetn(resetn), .start(start), .hold(hold), .in_valid(in_valid),
        .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_last(in_last),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .done(done),
        .clipped_count(clipped_count), .level(level));

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;
    always @(negedge clock) if (resetn && vga_plot) begin
        plots.push_back({vga_x, vga_y, vga_colour});
        plot_cyc.push_back(cyc);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock); #1;
        if (rhold) hold = ($urandom_range(0, 2) == 0);
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    function automatic logic [17:0] pix(input int x, input int y, input int c);
        logic [8:0] xx, yy;
        xx = 9'(x); yy = 9'(y);
        return {xx[7:0], yy[6:0], 3'(c)};
    endfunction

    // model: survivors are queued in order, everything else is counted
    task automatic send(input int x, input int y, input int c, input bit last);
        int n = 0;
        in_valid = 1; in_x = 9'(x); in_y = 9'(y); in_colour = 3'(c); in_last = last;
        while (!in_ready && n < 1000) begin step(); n++; end
        if (n >= 1000) chk("send_timeout", 0, 1);
        step();
        in_valid = 0; in_last = 0;
        if (x >= 0 && x <= 159 && y >= 0 && y <= 119) expq.push_back(pix(x, y, c));
        else exp_clip++;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 2000) begin step(); n++; end
        chk(name, done, 1);
    endtask

    task automatic new_shape();
        plots.delete(); plot_cyc.delete(); expq.delete(); exp_clip = 0;
        pulse_start();
    endtask

    task automatic compare_shape(input string name);
        chk({name, "_count"}, plots.size(), expq.size());
        for (int i = 0; i < plots.size() && i < expq.size(); i++) chk({name, "_pix"}, plots[i], expq[i]);
        chk({name, "_clip"}, clipped_count, exp_clip);
        chk({name, "_level"}, level, 0);
    endtask

    initial begin
        tbl[0]  = '{5, 7, 2, 1};     tbl[1]  = '{-1, 0, 1, 0};   tbl[2]  = '{160, 5, 3, 0};
        tbl[3]  = '{0, 120, 4, 0};   tbl[4]  = '{159, 119, 5, 1}; tbl[5]  = '{0, 0, 6, 1};
        tbl[6]  = '{200, 0, 7, 0};   tbl[7]  = '{-256, -256, 1, 0}; tbl[8] = '{255, 10, 2, 0};
        tbl[9]  = '{10, -1, 3, 0};   tbl[10] = '{0, 119, 4, 1};  tbl[11] = '{159, 0, 5, 1};

        step(); step();
        chk("rst_plot", vga_plot, 0); chk("rst_done", done, 0); chk("rst_level", level, 0);
        chk("rst_clip", clipped_count, 0); chk("rst_ready", in_ready, 0);
        chk("rst_vga", {vga_x, vga_y, vga_colour}, 0);
        resetn = 1; step();
        chk("idle_ready", in_ready, 0);

        new_shape();
        chk("run_ready", in_ready, 1);
        send(5, 7, 2, 1);
        chk("lat_n0_plot", vga_plot, 0); chk("lat_n0_done", done, 0);
        step();
        chk("lat_n1_plot", vga_plot, 1); chk("lat_n1_pix", {vga_x, vga_y, vga_colour}, pix(5, 7, 2));
        chk("lat_n1_done", done, 0);
        step();
        chk("lat_n2_plot", vga_plot, 0); chk("lat_n2_done", done, 1); chk("lat_clip", clipped_count, 0);
        chk("lat_hold_pix", {vga_x, vga_y, vga_colour}, pix(5, 7, 2));
        chk("done_ready", in_ready, 0);

        for (int i = 0; i < 12; i++) begin
            new_shape();
            send(tbl[i].x, tbl[i].y, tbl[i].c, 1);
            wait_done("tbl_done");
            chk("tbl_count", plots.size(), tbl[i].on);
            chk("tbl_pix", plots.size() > 0 ? int'(plots[0]) : -1, tbl[i].on ? int'(pix(tbl[i].x, tbl[i].y, tbl[i].c)) : -1);
            chk("tbl_clip", clipped_count, 1 - tbl[i].on);
        end

        new_shape();
        send(-1, 0, 1, 0); send(160, 5, 2, 0); send(0, 120, 3, 0); send(159, 119, 4, 1);
        wait_done("t2_done");
        compare_shape("t2");
        chk("t2_clip3", clipped_count, 3);

        new_shape();
        send(3, 3, 6, 0); send(200, 0, 1, 1);
        wait_done("t4_done");
        compare_shape("t4");

        hold = 1;
        new_shape();
        for (int i = 0; i < 16; i++) send(i, i, i % 8, 0);
        in_valid = 1;
        chk("t3_full_level", level, 16); chk("t3_full_ready", in_ready, 0);
        step();
        chk("t3_still_full", level, 16); chk("t3_no_plot", vga_plot, 0);
        hold = 0;
        for (int i = 16; i < 20; i++) send(i, i, i % 8, i == 19);
        wait_done("t3_done");
        compare_shape("t3");
        chk("t3_consecutive", plot_cyc.size() == 20 ? plot_cyc[19] - plot_cyc[0] : -1, 19);

        hold = 1;
        new_shape();
        for (int i = 0; i < 8; i++) send(10 + i, 20, 1, 0);
        chk("t5_level8", level, 8);
        resetn = 0; #1;
        chk("t5_rst_level", level, 0); chk("t5_rst_plot", vga_plot, 0); chk("t5_rst_done", done, 0);
        plots.delete();
        step(); resetn = 1; hold = 0;
        for (int i = 0; i < 20; i++) step();
        chk("t5_no_plots", plots.size(), 0); chk("t5_ready", in_ready, 0); chk("t5_done", done, 0);

        new_shape();
        send(200, 0, 1, 0); send(0, -5, 2, 1);
        wait_done("t6_done");
        chk("t6_clip2", clipped_count, 2);
        start = 1;
        step();
        start = 0;
        chk("t6_done_clr", done, 0); chk("t6_clip_clr", clipped_count, 0); chk("t6_ready", in_ready, 1);
        send(1, 1, 1, 1);
        wait_done("t6_redone");

        for (int s = 0; s < 6; s++) begin
            int n;
            rhold = 1;
            new_shape();
            n = $urandom_range(10, 40);
            for (int i = 0; i < n; i++) begin
                int g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) step();
                send($urandom_range(0, 200) - 20, $urandom_range(0, 160) - 20, $urandom_range(0, 7), i == n - 1);
            end
            wait_done("rnd_done");
            rhold = 0; hold = 0;
            compare_shape("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
